// File: rtl/texture_fetch_pkg.sv
// texture_fetch_pkg: shared video pipeline widths, scroll layout and latency
package texture_fetch_pkg;
  localparam int TILE_BITS = 6;
  localparam int TEX_AW = 12;
  localparam int MAP_AW = 10;
  localparam int TEXEL_W = 4;
  localparam int PIPE_LAT = 3;
  localparam int SCR_X_LSB = 0;
  localparam int SCR_Y_LSB = 8;
  typedef struct packed {
    logic [7:0] y;
    logic [7:0] x;
  } scroll_t;
endpackage

// File: rtl/scroll_shadow_reg.sv
// scroll_shadow_reg: pending/active scroll pair; active updates only at frame start
module scroll_shadow_reg
  import texture_fetch_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    wen,
  input  logic    load,
  input  scroll_t wdata,
  output scroll_t act
);
  scroll_t pend;
  always_ff @(posedge clk)
    if (reset) begin
      pend <= '0;
      act <= '0;
    end else begin
      if (wen) pend <= wdata;
      if (load) act <= wen ? wdata : pend;
    end
endmodule

// File: rtl/texture_fetch.sv
// texture_fetch: beam position + scroll -> tilemap -> texel, three-cycle fixed pipeline
module texture_fetch
  import texture_fetch_pkg::*;
#(
  parameter logic [TEXEL_W-1:0] TRANSPARENT_IDX = 4'd0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic [7:0]         h_pos,
  input  logic [7:0]         v_pos,
  input  logic               frame_start,
  input  logic               scroll_wen,
  input  logic [15:0]        scroll_wdata,
  output logic               map_ren,
  output logic [MAP_AW-1:0]  map_raddr,
  input  logic [7:0]         map_rdata,
  output logic               tex_ren,
  output logic [TEX_AW-1:0]  tex_raddr,
  input  logic [7:0]         tex_rdata,
  output logic               pix_out_valid,
  output logic [TEXEL_W-1:0] pix_color,
  output logic               pix_opaque
);
  scroll_t scr_act;
  logic [7:0] ex, ey;
  logic [2:0] ex1, ey1;
  logic v1, v2;
  logic unused_bits;
  scroll_shadow_reg u_scroll (
    .clk(clk),
    .reset(reset),
    .wen(scroll_wen),
    .load(frame_start),
    .wdata(scroll_wdata),
    .act(scr_act)
  );
  assign ex = h_pos + scr_act.x;
  assign ey = v_pos + scr_act.y;
  assign map_ren = pix_valid && !reset;
  assign map_raddr = {ey[7:3], ex[7:3]};
  assign tex_ren = v1;
  assign tex_raddr = {map_rdata[TILE_BITS-1:0], ey1, ex1};
  assign unused_bits = &{1'b0, map_rdata[7:TILE_BITS], tex_rdata[7:TEXEL_W]};
  always_ff @(posedge clk)
    if (reset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      ex1 <= '0;
      ey1 <= '0;
      pix_out_valid <= 1'b0;
      pix_color <= '0;
      pix_opaque <= 1'b0;
    end else begin
      v1 <= pix_valid;
      ex1 <= ex[2:0];
      ey1 <= ey[2:0];
      v2 <= v1;
      pix_out_valid <= v2;
      pix_color <= v2 ? tex_rdata[TEXEL_W-1:0] : '0;
      pix_opaque <= v2 && (tex_rdata[TEXEL_W-1:0] != TRANSPARENT_IDX);
    end
endmodule

// File: tb/tb_texture_fetch.sv
// tb_texture_fetch: table vectors plus directed sequences against memory-backed reference model
module tb_texture_fetch;
  logic clk = 1'b0;
  logic reset, pix_valid, frame_start, scroll_wen;
  logic [7:0] h_pos, v_pos, map_rdata, tex_rdata;
  logic [15:0] scroll_wdata;
  logic map_ren, tex_ren, pix_out_valid, pix_opaque;
  logic [9:0] map_raddr;
  logic [11:0] tex_raddr;
  logic [3:0] pix_color;
  logic [7:0] map_mem [1024];
  logic [7:0] tex_mem [4096];
  int tests = 0, fails = 0, out_cnt = 0;
  logic [15:0] m_pend, m_act;
  logic hv [1:3];
  logic [3:0] hc [1:3];
  logic [11:0] ht;
  logic [9:0] last_map;

  typedef struct {
    logic [7:0] h, v, sx, sy;
    logic [9:0] emap;
    logic [5:0] elow;
  } vec_t;
  vec_t tbl [5];

  texture_fetch dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .h_pos(h_pos), .v_pos(v_pos),
    .frame_start(frame_start), .scroll_wen(scroll_wen), .scroll_wdata(scroll_wdata),
    .map_ren(map_ren), .map_raddr(map_raddr), .map_rdata(map_rdata),
    .tex_ren(tex_ren), .tex_raddr(tex_raddr), .tex_rdata(tex_rdata),
    .pix_out_valid(pix_out_valid), .pix_color(pix_color), .pix_opaque(pix_opaque)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (map_ren) map_rdata <= map_mem[map_raddr];
    if (tex_ren) tex_rdata <= tex_mem[tex_raddr];
    out_cnt <= out_cnt + int'(pix_out_valid);
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] h, input logic [7:0] y,
                     input logic fs, input logic wen, input logic [15:0] wd, input logic rs);
    logic [7:0] ex, ey;
    logic [9:0] ma;
    logic [11:0] ta;
    logic [3:0] col;
    pix_valid = v; h_pos = h; v_pos = y; frame_start = fs;
    scroll_wen = wen; scroll_wdata = wd; reset = rs;
    ex = h + m_act[7:0];
    ey = y + m_act[15:8];
    ma = {ey[7:3], ex[7:3]};
    ta = {map_mem[ma][5:0], ey[2:0], ex[2:0]};
    col = tex_mem[ta][3:0];
    #1;
    if (!rs) begin
      chk("map_ren", int'(map_ren), int'(v));
      if (v) chk("map_raddr", int'(map_raddr), int'(ma));
      chk("tex_ren", int'(tex_ren), int'(hv[1]));
      if (hv[1]) chk("tex_raddr", int'(tex_raddr), int'(ht));
    end
    chk("pix_out_valid", int'(pix_out_valid), int'(hv[3]));
    chk("pix_color", int'(pix_color), hv[3] ? int'(hc[3]) : 0);
    chk("pix_opaque", int'(pix_opaque), int'(hv[3] && hc[3] != 4'd0));
    last_map = map_raddr;
    @(posedge clk);
    hv[3] = hv[2]; hc[3] = hc[2];
    hv[2] = hv[1]; hc[2] = hc[1];
    hv[1] = v; hc[1] = col; ht = ta;
    if (rs) begin
      hv[1] = 1'b0; hv[2] = 1'b0; hv[3] = 1'b0;
      m_pend = '0; m_act = '0;
    end else begin
      if (fs) m_act = wen ? wd : m_pend;
      if (wen) m_pend = wd;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0);
  endtask

  initial begin
    int snap;
    for (int i = 0; i < 1024; i++) map_mem[i] = 8'hC0 | 8'((i * 13 + 7) & 63);
    for (int i = 0; i < 4096; i++) tex_mem[i] = 8'hF0 | 8'((i ^ (i >> 4)) & 15);
    map_mem[0] = 8'hC5;
    tex_mem[12'h151] = 8'hFA;
    map_mem[1] = 8'hC7;
    tex_mem[12'h1C0] = 8'hF0;
    tbl[0] = '{8'd1, 8'd2, 8'd0, 8'd0, 10'd0, 6'h11};
    tbl[1] = '{8'd10, 8'd0, 8'd250, 8'd0, 10'd0, 6'h04};
    tbl[2] = '{8'd5, 8'd0, 8'd250, 8'd0, 10'd31, 6'h07};
    tbl[3] = '{8'd17, 8'd100, 8'd0, 8'd200, 10'd162, 6'h21};
    tbl[4] = '{8'd0, 8'd255, 8'd8, 8'd8, 10'd1, 6'h38};
    m_pend = '0; m_act = '0; ht = '0;
    for (int k = 1; k <= 3; k++) begin hv[k] = 1'b0; hc[k] = '0; end
    reset = 1'b1; pix_valid = 1'b0; h_pos = '0; v_pos = '0;
    frame_start = 1'b0; scroll_wen = 1'b0; scroll_wdata = '0;
    @(posedge clk); @(negedge clk);
    cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    chk("reset_valid", int'(pix_out_valid), 0);
    chk("reset_color", int'(pix_color), 0);
    chk("reset_tex_ren", int'(tex_ren), 0);

    // zero scroll: tile 5, texel 0xA
    cyc(1'b1, 8'd1, 8'd2, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("zs_map_raddr", int'(last_map), 0);
    chk("zs_tex_raddr", int'(tex_raddr), 12'h151);
    idle(2);
    chk("zs_color", int'(pix_color), 4'hA);
    chk("zs_opaque", int'(pix_opaque), 1);
    idle(1);

    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, {tbl[i].sy, tbl[i].sx}, 1'b0);
      cyc(1'b1, tbl[i].h, tbl[i].v, 1'b0, 1'b0, 16'd0, 1'b0);
      chk("tbl_map_raddr", int'(last_map), int'(tbl[i].emap));
      chk("tbl_tex_low", int'(tex_raddr[5:0]), int'(tbl[i].elow));
      idle(3);
    end

    // shadow: mid-frame write held until frame_start, then forwarding
    cyc(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 16'h0000, 1'b0);
    cyc(1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 16'h0008, 1'b0);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("shadow_hold", int'(last_map), 0);
    cyc(1'b0, 8'd0, 8'd0, 1'b1, 1'b0, 16'd0, 1'b0);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("shadow_load", int'(last_map), 1);
    cyc(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 16'h0010, 1'b0);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("shadow_fwd", int'(last_map), 2);
    idle(3);

    // transparency: tile 7 texel 0 with junk upper bits
    cyc(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 16'h0000, 1'b0);
    cyc(1'b1, 8'd8, 8'd0, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("tr_tex_raddr", int'(tex_raddr), 12'h1C0);
    idle(2);
    chk("tr_valid", int'(pix_out_valid), 1);
    chk("tr_color", int'(pix_color), 0);
    chk("tr_opaque", int'(pix_opaque), 0);
    idle(2);

    // streaming line with scroll applied
    cyc(1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 16'h2D13, 1'b0);
    snap = out_cnt;
    for (int i = 0; i < 256; i++) cyc(1'b1, 8'(i), 8'd40, 1'b0, 1'b0, 16'd0, 1'b0);
    idle(3);
    chk("stream_count", out_cnt - snap, 256);

    // reset with pixels in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(i * 9), 8'd3, 1'b0, 1'b0, 16'd0, 1'b0);
    cyc(1'b1, 8'd0, 8'd0, 1'b0, 1'b0, 16'd0, 1'b1);
    chk("rst_valid", int'(pix_out_valid), 0);
    snap = out_cnt;
    idle(4);
    chk("rst_no_output", out_cnt - snap, 0);

    // gaps 1,0,1
    cyc(1'b1, 8'd20, 8'd7, 1'b0, 1'b0, 16'd0, 1'b0);
    cyc(1'b0, 8'd21, 8'd7, 1'b0, 1'b0, 16'd0, 1'b0);
    cyc(1'b1, 8'd22, 8'd7, 1'b0, 1'b0, 16'd0, 1'b0);
    chk("gap_v0", int'(pix_out_valid), 1);
    idle(1);
    chk("gap_v1", int'(pix_out_valid), 0);
    chk("gap_c1", int'(pix_color), 0);
    idle(1);
    chk("gap_v2", int'(pix_out_valid), 1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
